// File: rtl/bc_pic_pkg.sv
// Shared definitions for the bc_pic interrupt controller: register map,
// source count and the fixed-priority encoder.
package bc_pic_pkg;

  localparam int PIC_NSRC        = 8;
  localparam int PIC_VEC_ANY_BIT = 7;

  typedef enum logic [2:0] {
    PIC_PEND  = 3'd0,
    PIC_MASK  = 3'd1,
    PIC_MODE  = 3'd2,
    PIC_VEC   = 3'd3,
    PIC_SWSET = 3'd4,
    PIC_CTRL  = 3'd5
  } pic_reg_e;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [2:0] pic_lowest(input logic [PIC_NSRC-1:0] v);
    logic [2:0] id;
    id = '0;
    for (int i = PIC_NSRC - 1; i >= 0; i--) begin
      if (v[i]) id = 3'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/bc_sync.sv
// Single-bit multi-flop synchronizer for asynchronous request lines.
module bc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bc_pic.sv
// Eight-source fixed-priority interrupt controller with per-source mask,
// edge/level mode, software set and vector-read acknowledge.
module bc_pic
  import bc_pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                cs,
  input  logic                rw,
  input  logic [2:0]          a,
  input  logic [7:0]          di,
  output logic [7:0]          dout,
  input  logic [PIC_NSRC-1:0] src,
  output logic                irq
);

  logic [PIC_NSRC-1:0] src_sync;
  logic [PIC_NSRC-1:0] prev_q, prev_d;
  logic [PIC_NSRC-1:0] pending_q, pending_d;
  logic [PIC_NSRC-1:0] mask_q, mask_d;
  logic [PIC_NSRC-1:0] mode_q, mode_d;
  logic                gen_q, gen_d;

  logic                wr_en, rd_en;
  logic [PIC_NSRC-1:0] pend, active, rise;
  logic [PIC_NSRC-1:0] set_bits, clr_bits;
  logic                any;
  logic [2:0]          id;
  logic [7:0]          rd_data;

  for (genvar i = 0; i < PIC_NSRC; i++) begin : g_sync
    bc_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (src[i]),
      .q       (src_sync[i])
    );
  end

  // Level-mode bits are the synchronized line itself; edge-mode bits are latched.
  always_comb begin
    wr_en  = ce & cs & ~rw;
    rd_en  = ce & cs & rw;
    pend   = (mode_q & pending_q) | (~mode_q & src_sync);
    active = pend & mask_q;
    any    = |active;
    id     = pic_lowest(active);
    rise   = src_sync & ~prev_q;
  end

  // A set in the same cycle as a clear wins; mode is applied after merging.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    set_bits = rise;
    clr_bits = '0;
    if (wr_en && a == PIC_SWSET) set_bits = set_bits | di;
    if (wr_en && a == PIC_PEND)  clr_bits = di;
    if (rd_en && a == PIC_VEC && any) clr_bits[id] = 1'b1;

    pending_d = (mode_q & ((pending_q & ~clr_bits) | set_bits)) | (~mode_q & src_sync);
    prev_d    = src_sync;

    mask_d = mask_q;
    mode_d = mode_q;
    gen_d  = gen_q;
    if (wr_en) begin
      case (a)
        PIC_MASK: mask_d = di;
        PIC_MODE: mode_d = di;
        PIC_CTRL: gen_d  = di[0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      gen_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      gen_q     <= gen_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (a)
      PIC_PEND: rd_data = pend;
      PIC_MASK: rd_data = mask_q;
      PIC_MODE: rd_data = mode_q;
      PIC_VEC: begin
        rd_data[PIC_VEC_ANY_BIT] = any;
        rd_data[2:0]             = id;
      end
      PIC_CTRL: rd_data[0] = gen_q;
      default:  rd_data = '0;
    endcase
  end

  assign irq  = gen_q & any;
  assign dout = (cs && rw) ? rd_data : 'z;

endmodule

// File: tb/tb_bc_pic.sv
// Directed scoreboard bench for bc_pic: register map, latency, ack, priority,
// set-beats-clear, masking and asynchronous reset.
module tb_bc_pic;
  import bc_pic_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce, cs, rw;
  logic [2:0] a;
  logic [7:0] di;
  logic [7:0] src;
  wire  [7:0] dout;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bc_pic #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .cs      (cs),
    .rw      (rw),
    .a       (a),
    .di      (di),
    .dout    (dout),
    .src     (src),
    .irq     (irq)
  );

  task automatic push_exp(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h, no expected value queued", obs);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [7:0] data);
    ce = 1'b1; cs = 1'b1; rw = 1'b0; a = addr; di = data;
    @(negedge clk);
    ce = 1'b0; cs = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] addr, input string tag, input logic [7:0] exp_val);
    push_exp(tag, exp_val);
    ce = 1'b1; cs = 1'b1; rw = 1'b1; a = addr;
    #1 check(dout);
    @(negedge clk);
    ce = 1'b0; cs = 1'b0; rw = 1'b1;
  endtask

  task automatic chk_irq(input string tag, input logic exp_irq);
    push_exp(tag, {7'b0, exp_irq});
    #1 check({7'b0, irq});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; ce = 1'b0; cs = 1'b0; rw = 1'b1; a = '0; di = '0; src = '0;
    tick(2);
    chk_irq("reset_irq", 1'b0);
    reset_n = 1'b1;
    tick(1);
    bus_read(PIC_PEND, "reset_pend", 8'h00);
    bus_read(PIC_MASK, "reset_mask", 8'h00);
    bus_read(PIC_MODE, "reset_mode", 8'h00);
    bus_read(PIC_VEC,  "reset_vec",  8'h00);
    bus_read(PIC_CTRL, "reset_ctrl", 8'h00);

    // Timer pulse: latency through the synchronizer, then vector ack.
    bus_write(PIC_MASK, 8'h01);
    bus_write(PIC_CTRL, 8'h01);
    bus_write(PIC_MODE, 8'h01);
    src = 8'h01;
    tick(1);
    src = 8'h00;
    tick(1);
    chk_irq("t1_irq_before_k2", 1'b0);
    tick(1);
    chk_irq("t1_irq_after_k2", 1'b1);
    bus_read(PIC_VEC,  "t1_vec", 8'h80);
    bus_read(PIC_PEND, "t1_pend_after_ack", 8'h00);
    chk_irq("t1_irq_after_ack", 1'b0);

    // Two simultaneous edges: priority order and successive acks.
    bus_write(PIC_MODE, 8'hFF);
    bus_write(PIC_MASK, 8'hFF);
    src = 8'h84;
    tick(3);
    bus_read(PIC_VEC, "t2_vec_first",  8'h82);
    bus_read(PIC_VEC, "t2_vec_second", 8'h87);
    bus_read(PIC_VEC, "t2_vec_empty",  8'h00);
    chk_irq("t2_irq_done", 1'b0);
    src = 8'h00;
    tick(3);

    // Level source: ack does not clear, dropping the line does.
    bus_write(PIC_MODE, 8'hF7);
    bus_write(PIC_MASK, 8'h08);
    src = 8'h08;
    tick(3);
    chk_irq("t3_irq_level", 1'b1);
    bus_read(PIC_VEC,  "t3_vec",           8'h83);
    bus_read(PIC_PEND, "t3_pend_after_ack", 8'h08);
    src = 8'h00;
    bus_read(PIC_PEND, "t3_pend_drop_c0", 8'h08);
    bus_read(PIC_PEND, "t3_pend_drop_c1", 8'h08);
    bus_read(PIC_PEND, "t3_pend_drop_c2", 8'h00);
    tick(2);

    // W1C in the same cycle as the hardware edge that sets the bit.
    src = 8'h20;
    tick(2);
    bus_write(PIC_PEND, 8'h20);
    bus_read(PIC_PEND, "t4_set_beats_clr", 8'h20);
    bus_write(PIC_PEND, 8'h20);
    bus_read(PIC_PEND, "t4_plain_w1c", 8'h00);

    // Masked edge still latches; mask and global enable gate irq.
    bus_write(PIC_MASK, 8'h00);
    src = 8'h04;
    tick(3);
    bus_read(PIC_PEND, "t5_masked_pend", 8'h04);
    chk_irq("t5_masked_irq", 1'b0);
    bus_write(PIC_MASK, 8'h04);
    chk_irq("t5_unmasked_irq", 1'b1);
    bus_write(PIC_CTRL, 8'h00);
    chk_irq("t5_gen_off_irq", 1'b0);

    // Asynchronous reset with everything pending and enabled.
    src = 8'h00;
    bus_write(PIC_MODE,  8'hFF);
    bus_write(PIC_SWSET, 8'hFF);
    bus_write(PIC_MASK,  8'hFF);
    bus_write(PIC_CTRL,  8'h01);
    bus_read(PIC_PEND, "t6_pend_full", 8'hFF);
    chk_irq("t6_irq_full", 1'b1);
    tick(2);
    reset_n = 1'b0;
    chk_irq("t6_irq_in_reset", 1'b0);
    tick(1);
    reset_n = 1'b1;
    bus_read(PIC_PEND,  "t6_pend_rst",  8'h00);
    bus_read(PIC_MASK,  "t6_mask_rst",  8'h00);
    bus_read(PIC_MODE,  "t6_mode_rst",  8'h00);
    bus_read(PIC_VEC,   "t6_vec_rst",   8'h00);
    bus_read(PIC_CTRL,  "t6_ctrl_rst",  8'h00);
    bus_write(3'd6, 8'hFF);
    bus_read(3'd6, "t6_addr6", 8'h00);
    bus_read(3'd7, "t6_addr7", 8'h00);
    chk_irq("t6_irq_rst", 1'b0);

    // Software set after reset; SWSET reads 0 and ignores level bits.
    bus_write(PIC_MODE,  8'h10);
    bus_write(PIC_MASK,  8'h10);
    bus_write(PIC_CTRL,  8'h01);
    bus_write(PIC_SWSET, 8'h10);
    chk_irq("t6_swset_irq", 1'b1);
    bus_read(PIC_PEND,  "t6_swset_pend", 8'h10);
    bus_read(PIC_SWSET, "t6_swset_read", 8'h00);
    bus_read(PIC_VEC,   "t6_swset_vec",  8'h84);
    chk_irq("t6_irq_after_ack", 1'b0);
    bus_write(PIC_SWSET, 8'h01);
    bus_read(PIC_PEND, "t6_swset_level_ignored", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
